hex_parse: RTL
==============

Name: hex_parse

Overview:
- Streaming ASCII-hex to binary decoder. It is the inverse of the on-screen hex digit renderer.
- It consumes a character stream (typically from the UART receiver) and assembles pairs of hex digits into bytes.
- Bytes are presented on a valid/ready output stream, for example to load memory or registers over the debug console.
- Separators and malformed input are handled explicitly, with error signalling.

Parameters:
- ALLOW_LOWER, 1: when 1, 'a'-'f' are accepted as hex digits; when 0 they are invalid characters.
- SEP_EMITS, 1: when 1, a separator after a single digit emits that digit as a byte (0x0N); when 0, it is an error.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a character
- in_data  input  8  ASCII character
- in_ready  output  1  character accepted when in_valid && in_ready
- out_valid  output  1  out_data holds a completed byte
- out_data  output  8  assembled byte, first digit in [7:4]
- out_ready  input  1  consumer takes the byte when out_valid && out_ready
- half  output  1  one hex digit is held (high nibble pending)
- err  output  1  one-cycle pulse on an invalid character
- err_cnt  output  8  saturating count of err pulses

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0x00, half=0, err=0, err_cnt=0. Internal held nibble is 0. State is EMPTY.
- Character classes:
  - digit: '0'-'9' map to 0-9; 'A'-'F' map to 10-15; 'a'-'f' map to 10-15 only if ALLOW_LOWER.
  - separator: 0x20 space, 0x09 tab, 0x0A LF, 0x0D CR, 0x2C ','.
  - invalid: everything else.
- in_ready = !out_valid || out_ready. Characters are accepted only when the output slot is free or is draining this cycle. in_ready does not depend on in_data.
- State machine, advancing only on an accepted character:
  - EMPTY + digit: hold the nibble, go to HALF.
  - EMPTY + separator: no action, stay in EMPTY.
  - EMPTY + invalid: err pulse, stay in EMPTY.
  - HALF + digit: load out_data={held, nibble}, set out_valid, go to EMPTY.
  - HALF + separator, SEP_EMITS=1: load out_data={4'h0, held}, set out_valid, go to EMPTY.
  - HALF + separator, SEP_EMITS=0: err pulse, drop the held nibble, go to EMPTY.
  - HALF + invalid: err pulse, drop the held nibble, go to EMPTY.
- half=1 exactly while in state HALF (a registered state bit).
- Latency: when the completing character is accepted in cycle N, out_valid=1 and out_data are valid in cycle N+1.
- out_valid and out_data stay stable until the handshake (out_valid && out_ready). out_valid clears on the handshake unless a new byte completes in the same cycle; if it does, out_valid stays 1 and out_data takes the new byte. There are no gaps and no byte is lost.
- err is registered: high for exactly the cycle after the accepted invalid character.
- err_cnt increments on each err pulse and saturates at 0xFF (no wrap).
- With in_valid=0 no state changes. A held nibble persists indefinitely.
- rst mid-byte drops the held nibble and any pending out_valid byte. err_cnt also clears.
- in_data is ignored when in_valid=0.

Test Plan:
- Pair decode: stream "3F" then "a5" with ALLOW_LOWER=1 and out_ready=1 -> out_data 0x3F, then 0xA5. Each out_valid appears one cycle after its second digit and lasts one cycle. half=1 between the digits.
- Back-pressure: out_ready=0 and send "12","34" back-to-back -> 0x12 is held stable and in_ready=0 blocks '3'. After one out_ready pulse, 0x12 is consumed and '3' is accepted in the same cycle. Then 0x34 appears. Nothing is dropped or duplicated.
- Separators: "7 ,\r\nBC" with SEP_EMITS=1 -> bytes 0x07 then 0xBC, no err. With SEP_EMITS=0 -> a single err pulse, then 0xBC only.
- Invalid handling: "4G2E" -> err pulse after 'G' and '4' is dropped. Then 0x2E is emitted, err_cnt=1. 'f' with ALLOW_LOWER=0 -> err pulse.
- Saturation: 300 invalid characters -> err_cnt stops at 0xFF and gives exactly 300 one-cycle err pulses.
- Reset mid-operation: send 'A', assert rst for one cycle, then send "55" -> out_data 0x55, not 0xA5. With out_valid pending, rst clears out_valid the next cycle. All outputs return to their reset values.

Source files
------------

// File: rtl/hex_parse.sv
// Streaming ASCII-hex to binary decoder: pairs of hex digits become bytes on a
// valid/ready output, with separator handling and a saturating error counter.
module hex_parse #(
    parameter bit ALLOW_LOWER = 1'b1,
    parameter bit SEP_EMITS   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       half,
    output logic       err,
    output logic [7:0] err_cnt
);

    typedef enum logic [0:0] {StEmpty, StHalf} state_e;
    typedef enum logic [1:0] {ClsDigit, ClsSep, ClsInvalid} cls_e;

    state_e     state_q, state_d;
    logic [3:0] nib_q, nib_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    cls_e       cls;
    logic [3:0] char_nib;
    logic       accept;

    // Output slot is free, or its byte leaves this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        cls      = ClsInvalid;
        char_nib = 4'h0;
        if (in_data >= 8'h30 && in_data <= 8'h39) begin
            cls      = ClsDigit;
            char_nib = in_data[3:0];
        end else if (in_data >= 8'h41 && in_data <= 8'h46) begin
            // 'A' is 0x41, so the low nibble plus 9 gives 10..15.
            cls      = ClsDigit;
            char_nib = in_data[3:0] + 4'd9;
        end else if (ALLOW_LOWER && in_data >= 8'h61 && in_data <= 8'h66) begin
            cls      = ClsDigit;
            char_nib = in_data[3:0] + 4'd9;
        end else if (in_data == 8'h20 || in_data == 8'h09 || in_data == 8'h0A ||
                     in_data == 8'h0D || in_data == 8'h2C) begin
            cls = ClsSep;
        end
    end

    always_comb begin
        state_d     = state_q;
        nib_d       = nib_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                StEmpty: begin
                    case (cls)
                        ClsDigit: begin
                            nib_d   = char_nib;
                            state_d = StHalf;
                        end
                        ClsInvalid: err_d = 1'b1;
                        default: ;
                    endcase
                end
                StHalf: begin
                    state_d = StEmpty;
                    nib_d   = 4'h0;
                    if (cls == ClsDigit) begin
                        out_valid_d = 1'b1;
                        out_data_d  = {nib_q, char_nib};
                    end else if (cls == ClsSep && SEP_EMITS) begin
                        out_valid_d = 1'b1;
                        out_data_d  = {4'h0, nib_q};
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end

        if (err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            nib_q       <= 4'h0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            nib_q       <= nib_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign half      = (state_q == StHalf);
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule
